// File: rtl/mod12_display_scan.sv
// Two-digit multiplexed 7-segment driver for a MOD12 counter value.
// Flags 11<->0 wrap events and latches illegal codes.
module mod12_display_scan #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] data_in,
  input  logic       mode,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       wrap_up,
  output logic       wrap_dn,
  output logic       err
);

  typedef enum logic {
    ONES,
    TENS
  } scan_t;

  localparam logic [7:0] DIV_LAST = 8'(SCAN_DIV - 1);

  scan_t       state;
  scan_t       state_nx;
  logic [7:0]  div;
  logic [7:0]  div_nx;
  logic [3:0]  data_q;
  logic        primed;
  logic [3:0]  ones;
  logic        tens;
  logic        illegal;
  logic [6:0]  seg_nx;
  logic [1:0]  an_nx;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] p;
    p = 7'h00;
    unique case (d)
      4'd0: p = 7'h3F;
      4'd1: p = 7'h06;
      4'd2: p = 7'h5B;
      4'd3: p = 7'h4F;
      4'd4: p = 7'h66;
      4'd5: p = 7'h6D;
      4'd6: p = 7'h7D;
      4'd7: p = 7'h07;
      4'd8: p = 7'h7F;
      4'd9: p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // BCD split of the registered count
  always_comb begin
    illegal = data_q > 4'd11;
    tens    = 1'b0;
    ones    = data_q;
    if (data_q >= 4'd10) begin
      tens = 1'b1;
      ones = data_q - 4'd10;
    end
  end

  // Scan divider/state advance and next display pattern
  always_comb begin
    div_nx   = div + 8'd1;
    state_nx = state;
    an_nx    = 2'b01;
    seg_nx   = 7'h00;
    if (div == DIV_LAST) begin
      div_nx   = 8'd0;
      state_nx = (state == ONES) ? TENS : ONES;
    end
    if (state == TENS) begin
      an_nx = 2'b10;
    end
    if (illegal) begin
      seg_nx = 7'h40;
    end else if (state == ONES) begin
      seg_nx = enc(ones);
    end else if (tens) begin
      seg_nx = enc(4'd1);
    end
  end

  // Scan FSM and registered display outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ONES;
      div   <= 8'd0;
      an    <= 2'b00;
      seg   <= 7'h00;
    end else begin
      state <= state_nx;
      div   <= div_nx;
      an    <= an_nx;
      seg   <= seg_nx;
    end
  end

  // Input sampling, wrap detection and sticky error
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_q  <= 4'd0;
      primed  <= 1'b0;
      wrap_up <= 1'b0;
      wrap_dn <= 1'b0;
      err     <= 1'b0;
    end else begin
      data_q  <= data_in;
      primed  <= 1'b1;
      wrap_up <= primed & (data_q == 4'd11)
                 & (data_in == 4'd0) & mode;
      wrap_dn <= primed & (data_q == 4'd0)
                 & (data_in == 4'd11) & ~mode;
      if (data_in > 4'd11) begin
        err <= 1'b1;
      end
    end
  end

endmodule
